// File: rtl/timer_pkg.sv
// Shared constants for the game countdown timer and its display consumer:
// 7-segment glyphs, scan digit indices and the timer's reset value.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned ANODE_W = 4;
  localparam int unsigned IDX_W   = 2;

  typedef logic [GLYPH_W-1:0] glyph_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam glyph_t GLYPH_0     = 7'b1000000;
  localparam glyph_t GLYPH_1     = 7'b1111001;
  localparam glyph_t GLYPH_2     = 7'b0100100;
  localparam glyph_t GLYPH_3     = 7'b0110000;
  localparam glyph_t GLYPH_4     = 7'b0011001;
  localparam glyph_t GLYPH_5     = 7'b0010010;
  localparam glyph_t GLYPH_6     = 7'b0000010;
  localparam glyph_t GLYPH_7     = 7'b1111000;
  localparam glyph_t GLYPH_8     = 7'b0000000;
  localparam glyph_t GLYPH_9     = 7'b0010000;
  localparam glyph_t GLYPH_DASH  = 7'b0111111;
  localparam glyph_t GLYPH_P     = 7'b0001100;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;

  localparam idx_t IDX_SEC2 = 2'd0;
  localparam idx_t IDX_SEC1 = 2'd1;
  localparam idx_t IDX_MIN  = 2'd2;
  localparam idx_t IDX_STAT = 2'd3;

  localparam digit_t MIN_INIT  = 4'd2;
  localparam digit_t SEC1_INIT = 4'd0;
  localparam digit_t SEC2_INIT = 4'd0;

  typedef struct packed {
    digit_t min;
    digit_t sec1;
    digit_t sec2;
  } digits_t;

  localparam digits_t DIGITS_INIT = '{min: MIN_INIT, sec1: SEC1_INIT, sec2: SEC2_INIT};

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment glyph; non-BCD codes show a dash.
module bcd_to_seg
  import timer_pkg::*;
(
  input  digit_t bcd,
  output glyph_t seg_c
);

  always_comb begin
    seg_c = GLYPH_DASH;
    case (bcd)
      4'd0:    seg_c = GLYPH_0;
      4'd1:    seg_c = GLYPH_1;
      4'd2:    seg_c = GLYPH_2;
      4'd3:    seg_c = GLYPH_3;
      4'd4:    seg_c = GLYPH_4;
      4'd5:    seg_c = GLYPH_5;
      4'd6:    seg_c = GLYPH_6;
      4'd7:    seg_c = GLYPH_7;
      4'd8:    seg_c = GLYPH_8;
      4'd9:    seg_c = GLYPH_9;
      default: seg_c = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// Samples the timer's BCD digits once per frame, multiplexes them onto a
// 4-digit common-anode display, and flags/blinks on the 0:00 timeout.
module timer_display
  import timer_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] min,
  input  logic [DIGIT_W-1:0] sec1,
  input  logic [DIGIT_W-1:0] sec2,
  input  logic               running,
  output logic [ANODE_W-1:0] an,
  output logic [SEG_W-1:0]   seg,
  output logic               time_up,
  output logic               time_up_pulse
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  idx_t               idx;
  digits_t            shadow;
  logic               blink_on;

  logic               scan_tc;
  logic               blink_tc;
  logic               time_up_nxt;
  digit_t             digit_c;
  glyph_t             glyph_c;
  logic [ANODE_W-1:0] an_nxt;
  logic [SEG_W-1:0]   seg_nxt;

  assign scan_tc     = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_tc    = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign time_up_nxt = (shadow == digits_t'(0)) && running;

  // Scan position; the shadow only reloads on the 3->0 wrap so a frame never mixes samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= IDX_SEC2;
      shadow   <= DIGITS_INIT;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx + IDX_W'(1);
      if (idx == IDX_STAT) shadow <= {min, sec1, sec2};
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    digit_c = shadow.sec2;
    case (idx)
      IDX_SEC1: digit_c = shadow.sec1;
      IDX_MIN:  digit_c = shadow.min;
      default:  digit_c = shadow.sec2;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd   (digit_c),
    .seg_c (glyph_c)
  );

  // Leftmost digit is a status cell: 'P' while paused, blank otherwise
  always_comb begin
    an_nxt  = {ANODE_W{1'b1}};
    seg_nxt = {1'b1, GLYPH_BLANK};
    if (blink_on) an_nxt = ~(ANODE_W'(1) << idx);
    case (idx)
      IDX_MIN:  seg_nxt = {1'b0, glyph_c};
      IDX_STAT: if (!running && !time_up) seg_nxt = {1'b1, GLYPH_P};
      default:  seg_nxt = {1'b1, glyph_c};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= {ANODE_W{1'b1}};
      seg <= {SEG_W{1'b1}};
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_up       <= 1'b0;
      time_up_pulse <= 1'b0;
    end else begin
      time_up       <= time_up_nxt;
      time_up_pulse <= time_up_nxt && !time_up;
    end
  end

  // Blink phase only advances while timed out and restarts lit when it clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!time_up) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_tc) begin
      blink_cnt <= '0;
      blink_on  <= !blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Frame-level bench for timer_display: vector table with a frame scoreboard,
// plus hand-written timeout, blink, reset and re-assertion sequences.
`timescale 1ns/1ps
module tb_timer_display;
  import timer_pkg::*;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 16;
  localparam int unsigned FRAME     = 4 * SCAN_DIV;
  localparam int unsigned NVEC      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] min, sec1, sec2;
  logic       running;
  logic [3:0] an;
  logic [7:0] seg;
  logic       time_up, time_up_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] min, sec1, sec2;
    logic       running;
    logic [7:0] s0, s1, s2;
  } vec_t;

  typedef struct {
    logic [7:0] s0, s1, s2;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  timer_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .min           (min),
    .sec1          (sec1),
    .sec2          (sec2),
    .running       (running),
    .an            (an),
    .seg           (seg),
    .time_up       (time_up),
    .time_up_pulse (time_up_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    min     = v.min;
    sec1    = v.sec1;
    sec2    = v.sec2;
    running = v.running;
  endtask

  // One 16-cycle frame: compares every cycle against the oldest scoreboard entry;
  // optionally applies a new vector mid-frame (idx=1) and queues what it must show next frame
  task automatic do_frame(input bit apply, input vec_t v, input string tag);
    exp_t       e;
    logic [7:0] es;
    int         d;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s sb_empty: got 0 entries, expected 1", tag);
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c < int'(FRAME); c++) begin
      @(posedge clk); #1;
      d = c / int'(SCAN_DIV);
      case (d)
        0:       es = e.s0;
        1:       es = e.s1;
        2:       es = e.s2;
        default: es = running ? 8'hFF : 8'h8C;
      endcase
      check($sformatf("%s an c%0d", tag, c), 32'(an), 32'(4'hF ^ (4'd1 << d)));
      check($sformatf("%s seg c%0d", tag, c), 32'(seg), 32'(es));
      if (apply && c == 5) begin
        drive(v);
        sb.push_back('{v.s0, v.s1, v.s2});
      end
    end
    check($sformatf("%s time_up", tag), 32'(time_up), 32'd0);
    check($sformatf("%s pulse", tag), 32'(time_up_pulse), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       zero_v;
    exp_t       init_e;
    int         pulses;
    logic       blank_exp;

    //        min   sec1  sec2  run   s0     s1     s2(dp)
    vecs[0] = '{4'd1, 4'd3, 4'd7, 1'b1, 8'hF8, 8'hB0, 8'h79};
    vecs[1] = '{4'd0, 4'd4, 4'd5, 1'b0, 8'h92, 8'h99, 8'h40};
    vecs[2] = '{4'd0, 4'd4, 4'd5, 1'b1, 8'h92, 8'h99, 8'h40};
    vecs[3] = '{4'd0, 4'd1, 4'd0, 1'b1, 8'hC0, 8'hF9, 8'h40};
    vecs[4] = '{4'd0, 4'd0, 4'd9, 1'b1, 8'h90, 8'hC0, 8'h40};
    vecs[5] = '{4'hC, 4'd5, 4'd9, 1'b1, 8'h90, 8'h92, 8'h3F};
    vecs[6] = '{4'd9, 4'd5, 4'hF, 1'b0, 8'hBF, 8'h92, 8'h10};
    vecs[7] = '{4'd8, 4'd6, 4'd2, 1'b0, 8'hA4, 8'h82, 8'h00};
    zero_v  = '{4'd0, 4'd0, 4'd0, 1'b1, 8'hC0, 8'hC0, 8'h40};
    init_e  = '{8'hC0, 8'hC0, 8'h24};

    // Reset with 1:37 on the bus; first frame must still show 2:00
    drive(vecs[0]);
    sb.push_back(init_e);
    sb.push_back('{vecs[0].s0, vecs[0].s1, vecs[0].s2});
    #12;
    check("rst an", 32'(an), 32'hF);
    check("rst seg", 32'(seg), 32'hFF);
    check("rst time_up", 32'(time_up), 32'd0);
    check("rst pulse", 32'(time_up_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_frame(1'b0, vecs[0], "frame0");
    for (int k = 1; k < int'(NVEC); k++)
      do_frame(1'b1, vecs[k], $sformatf("vec%0d", k));

    // 0:00 with running: shown after the next wrap, which must time out
    drive(zero_v);
    do_frame(1'b0, zero_v, "last_vec");

    pulses = 0;
    for (int t = 1; t <= 64; t++) begin
      @(posedge clk); #1;
      if (time_up_pulse) pulses++;
      if (t == 1) check("tu pulse first", 32'(time_up_pulse), 32'd1);
      check($sformatf("tu level t%0d", t), 32'(time_up), 32'd1);
      blank_exp = (t >= 18 && t <= 33) || (t >= 50);
      if (blank_exp)
        check($sformatf("blink off an t%0d", t), 32'(an), 32'hF);
      else
        check($sformatf("blink on onehot t%0d", t), 32'($countones(~an)), 32'd1);
    end
    check("tu pulse count", 32'(pulses), 32'd1);

    // Asynchronous reset while timed out
    #2 rst = 1'b0;
    #1;
    check("rst2 an", 32'(an), 32'hF);
    check("rst2 seg", 32'(seg), 32'hFF);
    check("rst2 time_up", 32'(time_up), 32'd0);
    check("rst2 pulse", 32'(time_up_pulse), 32'd0);
    sb.push_back(init_e);
    @(negedge clk);
    rst = 1'b1;
    do_frame(1'b0, zero_v, "post_rst");

    @(posedge clk); #1;
    check("rearm time_up", 32'(time_up), 32'd1);
    check("rearm pulse", 32'(time_up_pulse), 32'd1);
    @(posedge clk); #1;
    check("rearm pulse end", 32'(time_up_pulse), 32'd0);
    check("rearm hold", 32'(time_up), 32'd1);
    running = 1'b0;
    @(posedge clk); #1;
    check("stop clears", 32'(time_up), 32'd0);
    check("stop no pulse", 32'(time_up_pulse), 32'd0);
    running = 1'b1;
    @(posedge clk); #1;
    check("reassert level", 32'(time_up), 32'd1);
    check("reassert pulse", 32'(time_up_pulse), 32'd1);
    @(posedge clk); #1;
    check("reassert pulse end", 32'(time_up_pulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
